data_proc_run_ctrl: RTL and testbench

Run sequencer for the data_proc HLS kernel under the ap_ctrl_hs protocol. It issues a programmed number of kernel runs, or runs continuously, and counts completions. A watchdog on the deadlock monitor's block output aborts a stuck run, pulses a kernel soft reset and latches a sticky deadlock flag. The block sits between the host config/status registers and the kernel's ap_start/ap_ready/ap_done/ap_idle pins.

---
 rtl/data_proc_run_ctrl.sv | 172 +++++++++++++++++
 tb/tb_data_proc_run_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_proc_run_ctrl.sv
// data_proc_run_ctrl: ap_ctrl_hs run sequencer for the data_proc HLS kernel.
// Issues a programmed number of kernel runs (or runs continuously until stopped), counts
// completions, and aborts a stuck run when the deadlock monitor's block output persists.
// Optional feature macro: DATA_PROC_RUN_CYCLE_CNT_EN enables the per-run cycle counter that
// drives last_run_cycles; without it last_run_cycles is tied to 0.
module data_proc_run_ctrl #(
   parameter int unsigned RUN_CNT_W      = 16,
   parameter int unsigned WDOG_W         = 20,
   parameter int unsigned WDOG_LIMIT     = 4096,
   parameter int unsigned RECOVER_CYCLES = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 cfg_start,
   input  logic                 cfg_stop,
   input  logic                 cfg_continuous,
   input  logic [RUN_CNT_W-1:0] cfg_num_runs,
   output logic                 ap_start,
   input  logic                 ap_ready,
   input  logic                 ap_done,
   input  logic                 ap_idle,
   input  logic                 dl_block,
   output logic                 kernel_rst,
   output logic                 busy,
   output logic                 done_pulse,
   output logic                 deadlock_flag,
   output logic [RUN_CNT_W-1:0] run_count,
   output logic [31:0]          last_run_cycles
);

   localparam int unsigned RecW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
   localparam logic [WDOG_W-1:0] WdogLast = WDOG_W'(WDOG_LIMIT - 1);
   localparam logic [RecW-1:0]   RecLast  = RecW'(RECOVER_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StIssue, StWait, StRecover, StFinish} state_e;

   state_e                 state_q;
   logic [RUN_CNT_W-1:0]   num_runs_q;
   logic                   cont_q;
   logic                   stop_pend_q;
   logic [WDOG_W-1:0]      wdog_q;
   logic [RecW-1:0]        rec_q;

   logic [WDOG_W-1:0]      wdog_inc;
   logic                   wdog_trip;
   logic [RUN_CNT_W-1:0]   run_inc;
   logic                   seq_end;
   logic                   run_done;

   // ap_idle is informational only; it never steers sequencing
   logic unused_ap_idle;
   assign unused_ap_idle = ap_idle;

   // Watchdog trip, run completion and end-of-sequence decisions for the current cycle
   always_comb begin
      wdog_inc  = wdog_q + 1'b1;
      wdog_trip = dl_block && (wdog_q == WdogLast);
      run_inc   = run_count + 1'b1;
      // A stop arriving together with ap_done still ends the sequence after this run
      seq_end   = (!cont_q && (run_inc == num_runs_q)) || stop_pend_q || cfg_stop;
      // Completion: ap_done in WAIT, or ap_done in the same cycle the start is accepted
      run_done  = ap_done && ((state_q == StWait) ||
                              ((state_q == StIssue) && ap_start && ap_ready));
   end

   // Sequencer FSM; every output is a register updated here
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= StIdle;
         ap_start      <= 1'b0;
         kernel_rst    <= 1'b0;
         busy          <= 1'b0;
         done_pulse    <= 1'b0;
         deadlock_flag <= 1'b0;
         run_count     <= '0;
         num_runs_q    <= '0;
         cont_q        <= 1'b0;
         stop_pend_q   <= 1'b0;
         wdog_q        <= '0;
         rec_q         <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               wdog_q <= '0;
               if (cfg_start && ((cfg_num_runs != '0) || cfg_continuous)) begin
                  num_runs_q    <= cfg_num_runs;
                  cont_q        <= cfg_continuous;
                  run_count     <= '0;
                  deadlock_flag <= 1'b0;
                  busy          <= 1'b1;
                  state_q       <= StIssue;
               end
            end
            StIssue, StWait: begin
               if (cfg_stop) stop_pend_q <= 1'b1;
               // Consecutive block cycles are counted across ISSUE/WAIT hand-offs
               wdog_q <= dl_block ? wdog_inc : '0;
               if (wdog_trip) begin
                  state_q       <= StRecover;
                  ap_start      <= 1'b0;
                  deadlock_flag <= 1'b1;
                  kernel_rst    <= 1'b1;
                  rec_q         <= '0;
                  wdog_q        <= '0;
               end else if (run_done) begin
                  ap_start  <= 1'b0;
                  run_count <= run_inc;
                  if (seq_end) begin
                     state_q    <= StFinish;
                     done_pulse <= 1'b1;
                     wdog_q     <= '0;
                  end else begin
                     state_q <= StIssue;
                  end
               end else if (state_q == StIssue) begin
                  if (ap_start && ap_ready) begin
                     ap_start <= 1'b0;
                     state_q  <= StWait;
                  end else begin
                     ap_start <= 1'b1;
                  end
               end
            end
            StRecover: begin
               if (rec_q == RecLast) begin
                  state_q     <= StIdle;
                  kernel_rst  <= 1'b0;
                  busy        <= 1'b0;
                  stop_pend_q <= 1'b0;
               end else begin
                  rec_q <= rec_q + 1'b1;
               end
            end
            StFinish: begin
               state_q     <= StIdle;
               done_pulse  <= 1'b0;
               busy        <= 1'b0;
               stop_pend_q <= 1'b0;
            end
            default: begin
               state_q    <= StIdle;
               ap_start   <= 1'b0;
               kernel_rst <= 1'b0;
               busy       <= 1'b0;
               done_pulse <= 1'b0;
            end
         endcase
      end
   end

`ifdef DATA_PROC_RUN_CYCLE_CNT_EN
   logic [31:0] cyc_q;

   // Per-run cycle counter: 1 in the first ap_start cycle, saturating; captured on completion
   always_ff @(posedge clock) begin
      if (reset) begin
         cyc_q           <= '0;
         last_run_cycles <= '0;
      end else begin
         if ((state_q == StIssue) && !ap_start && !wdog_trip) begin
            cyc_q <= 32'd1;
         end else if (cyc_q != '1) begin
            cyc_q <= cyc_q + 1'b1;
         end
         if (run_done && !wdog_trip) last_run_cycles <= cyc_q;
      end
   end
`else
   assign last_run_cycles = '0;
`endif

endmodule

// File: tb/tb_data_proc_run_ctrl.sv
// Self-checking bench for data_proc_run_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a phase-level behavioural model.
module tb_data_proc_run_ctrl;

   localparam int unsigned RunW      = 4;
   localparam int unsigned WdogLimit = 8;
   localparam int unsigned RecCycles = 16;
`ifdef DATA_PROC_RUN_CYCLE_CNT_EN
   localparam bit CntEn = 1'b1;
`else
   localparam bit CntEn = 1'b0;
`endif

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic            cfg_start = 1'b0;
   logic            cfg_stop = 1'b0;
   logic            cfg_continuous = 1'b0;
   logic [RunW-1:0] cfg_num_runs = '0;
   logic            ap_start;
   logic            ap_ready = 1'b0;
   logic            ap_done = 1'b0;
   logic            ap_idle = 1'b1;
   logic            dl_block = 1'b0;
   logic            kernel_rst;
   logic            busy;
   logic            done_pulse;
   logic            deadlock_flag;
   logic [RunW-1:0] run_count;
   logic [31:0]     last_run_cycles;

   always #5 clock = ~clock;

   data_proc_run_ctrl #(
      .RUN_CNT_W      (RunW),
      .WDOG_W         (20),
      .WDOG_LIMIT     (WdogLimit),
      .RECOVER_CYCLES (RecCycles)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .cfg_start       (cfg_start),
      .cfg_stop        (cfg_stop),
      .cfg_continuous  (cfg_continuous),
      .cfg_num_runs    (cfg_num_runs),
      .ap_start        (ap_start),
      .ap_ready        (ap_ready),
      .ap_done         (ap_done),
      .ap_idle         (ap_idle),
      .dl_block        (dl_block),
      .kernel_rst      (kernel_rst),
      .busy            (busy),
      .done_pulse      (done_pulse),
      .deadlock_flag   (deadlock_flag),
      .run_count       (run_count),
      .last_run_cycles (last_run_cycles)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: dut=%0d expected=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model (phase level) ----------------
   typedef enum int {MIdle, MIssue, MWait, MRecover, MFinish} mph_e;
   mph_e   m_ph = MIdle;
   bit     m_started = 1'b0;
   bit     m_cont = 1'b0;
   bit     m_stop = 1'b0;
   bit     m_flag = 1'b0;
   int     m_runs = 0;
   int     m_count = 0;
   int     m_blk = 0;
   int     m_rec_left = 0;
   longint m_cyc = 0;
   longint m_last = 0;

   always @(posedge clock) begin : model
      bit accepted;
      bit completed;
      bit just_started;
      just_started = 1'b0;
      if (reset) begin
         m_ph = MIdle; m_started = 0; m_cont = 0; m_stop = 0; m_flag = 0;
         m_runs = 0; m_count = 0; m_blk = 0; m_rec_left = 0; m_cyc = 0; m_last = 0;
      end else begin
         case (m_ph)
            MIdle: begin
               if (cfg_start && (cfg_num_runs != 0 || cfg_continuous)) begin
                  m_runs = int'(cfg_num_runs);
                  m_cont = cfg_continuous;
                  m_count = 0;
                  m_flag = 0;
                  m_blk = 0;
                  m_started = 0;
                  m_ph = MIssue;
               end
            end
            MIssue, MWait: begin
               if (cfg_stop) m_stop = 1;
               m_blk = dl_block ? m_blk + 1 : 0;
               if (m_blk >= int'(WdogLimit)) begin
                  m_ph = MRecover;
                  m_rec_left = RecCycles;
                  m_flag = 1;
                  m_blk = 0;
               end else begin
                  accepted  = (m_ph == MIssue) && m_started && ap_ready;
                  completed = ap_done && ((m_ph == MWait) || accepted);
                  if (completed) begin
                     m_count = (m_count + 1) % (1 << RunW);
                     m_last = m_cyc;
                     if ((!m_cont && m_count == m_runs) || m_stop) m_ph = MFinish;
                     else begin
                        m_ph = MIssue;
                        m_started = 0;
                     end
                  end else if (accepted) begin
                     m_ph = MWait;
                  end else if (m_ph == MIssue && !m_started) begin
                     m_started = 1;
                     just_started = 1;
                  end
               end
            end
            MRecover: begin
               m_rec_left--;
               if (m_rec_left == 0) begin
                  m_ph = MIdle;
                  m_stop = 0;
               end
            end
            default: begin
               m_ph = MIdle;
               m_stop = 0;
            end
         endcase
         if (just_started) m_cyc = 1;
         else if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
      end
   end

   // Single compare process: every cycle, away from the active edge
   always @(negedge clock) begin : compare
      if (chk_en) begin
         check("ap_start", ap_start, (m_ph == MIssue) && m_started);
         check("busy", busy, m_ph != MIdle);
         check("done_pulse", done_pulse, m_ph == MFinish);
         check("kernel_rst", kernel_rst, m_ph == MRecover);
         check("deadlock_flag", deadlock_flag, m_flag);
         check("run_count", run_count, m_count);
         check("last_run_cycles", last_run_cycles, CntEn ? m_last : 0);
      end
   end

   // ---------------- kernel responder ----------------
   bit k_rand = 1'b0;
   int k_fix_r = 1;
   int k_fix_d = 1;
   int kst = 0;
   int kcnt = 0;
   int k_d = 0;

   task automatic k_fire_ready();
      ap_ready = 1'b1;
      if (k_d == 0) begin
         ap_done = 1'b1;
         kst = 3;
      end else begin
         kcnt = k_d;
         kst = 2;
      end
   endtask

   always @(negedge clock) begin : kernel
      int r;
      if (reset || kernel_rst || !busy) begin
         kst = 0;
         ap_ready = 1'b0;
         ap_done = k_rand && !reset && ($urandom_range(0, 19) == 0);
      end else begin
         ap_ready = 1'b0;
         ap_done = 1'b0;
         case (kst)
            0: if (ap_start) begin
               r   = k_rand ? int'($urandom_range(0, 3)) : k_fix_r;
               k_d = k_rand ? int'($urandom_range(0, 12)) : k_fix_d;
               if (r == 0) k_fire_ready();
               else begin
                  kcnt = r;
                  kst = 1;
               end
            end
            1: begin
               kcnt--;
               if (kcnt == 0) k_fire_ready();
            end
            2: begin
               kcnt--;
               if (kcnt == 0) begin
                  ap_done = 1'b1;
                  kst = 3;
               end
            end
            default: kst = 0;
         endcase
      end
      ap_idle = (kst == 0);
   end

   // ---------------- event monitor for literal checks ----------------
   int   hs_cnt = 0;
   int   rise_cnt = 0;
   int   dp_cnt = 0;
   int   kr_cnt = 0;
   logic start_prev = 1'b0;

   always @(posedge clock) begin : monitor
      if (ap_start && ap_ready) hs_cnt++;
      if (ap_start && !start_prev) rise_cnt++;
      start_prev = ap_start;
      if (done_pulse) dp_cnt++;
      if (kernel_rst) kr_cnt++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic start_seq(input int n, input bit c);
      @(negedge clock);
      cfg_num_runs = RunW'(n);
      cfg_continuous = c;
      cfg_start = 1'b1;
      @(negedge clock);
      cfg_start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int max);
      int i;
      i = 0;
      while (busy && i < max) begin
         @(negedge clock);
         i++;
      end
      check(name, busy, 0);
   endtask

   task automatic wait_hs(input string name, input int target, input int max);
      int i;
      i = 0;
      while (hs_cnt < target && i < max) begin
         @(negedge clock);
         i++;
      end
      check(name, hs_cnt >= target, 1);
   endtask

   int hs0, rise0, dp0, kr0;
   int blk_left;

   task automatic snap();
      hs0 = hs_cnt; rise0 = rise_cnt; dp0 = dp_cnt; kr0 = kr_cnt;
   endtask

   initial begin
      blk_left = 0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      chk_en = 1'b1;
      // Reset state
      check("rst_busy", busy, 0);
      check("rst_ap_start", ap_start, 0);
      check("rst_kernel_rst", kernel_rst, 0);
      check("rst_flag", deadlock_flag, 0);
      check("rst_run_count", run_count, 0);
      check("rst_done_pulse", done_pulse, 0);
      check("rst_last_cycles", last_run_cycles, 0);

      // Three runs: ready 2 cycles after start, done 10 cycles after ready
      k_fix_r = 2; k_fix_d = 10; snap();
      start_seq(3, 0);
      wait_idle("three_idle", 200);
      check("three_handshakes", hs_cnt - hs0, 3);
      check("three_run_count", run_count, 3);
      check("three_done_pulses", dp_cnt - dp0, 1);

      // Cycle counter: ap_start first high at T, ap_done at T+11
      k_fix_r = 1; k_fix_d = 10;
      start_seq(1, 0);
      wait_idle("cyc_idle", 100);
      check("cyc_last_run_cycles", last_run_cycles, CntEn ? 12 : 0);

      // Ready and done in the same cycle, single run
      k_fix_r = 0; k_fix_d = 0; snap();
      start_seq(1, 0);
      wait_idle("same_idle", 50);
      check("same_run_count", run_count, 1);
      check("same_done_pulses", dp_cnt - dp0, 1);
      check("same_start_rises", rise_cnt - rise0, 1);

      // Zero runs, not continuous: ignored
      start_seq(0, 0);
      check("zero_busy", busy, 0);
      check("zero_run_count", run_count, 1);

      // Continuous, stop during run 5
      k_fix_r = 1; k_fix_d = 6; snap();
      start_seq(0, 1);
      wait_hs("cont_reach5", hs0 + 5, 300);
      @(negedge clock); cfg_stop = 1'b1;
      @(negedge clock); cfg_stop = 1'b0;
      wait_idle("cont_idle", 100);
      check("cont_run_count", run_count, 5);
      check("cont_start_rises", rise_cnt - rise0, 5);
      check("cont_done_pulses", dp_cnt - dp0, 1);

      // cfg_start while busy is ignored
      k_fix_r = 1; k_fix_d = 4;
      start_seq(2, 0);
      repeat (3) @(negedge clock);
      start_seq(7, 0);
      wait_idle("busy_start_idle", 100);
      check("busy_start_run_count", run_count, 2);

      // Watchdog trip during WAIT of run 2
      k_fix_r = 1; k_fix_d = 30; snap();
      start_seq(2, 0);
      wait_hs("wd_reach2", hs0 + 2, 200);
      dl_block = 1'b1;
      wait_idle("wd_idle", 100);
      dl_block = 1'b0;
      check("wd_flag", deadlock_flag, 1);
      check("wd_kernel_rst_cycles", kr_cnt - kr0, 16);
      check("wd_done_pulses", dp_cnt - dp0, 0);
      check("wd_run_count", run_count, 1);

      // Block high 7, low 1, repeated: no trip
      k_fix_r = 1; k_fix_d = 60;
      start_seq(1, 0);
      for (int rep = 0; rep < 6; rep++) begin
         for (int j = 0; j < 7; j++) begin
            dl_block = 1'b1;
            @(negedge clock);
         end
         dl_block = 1'b0;
         @(negedge clock);
      end
      wait_idle("nowd_idle", 100);
      check("nowd_flag", deadlock_flag, 0);
      check("nowd_run_count", run_count, 1);

      // Reset during WAIT: all outputs 0 the next cycle
      k_fix_r = 1; k_fix_d = 20; snap();
      start_seq(2, 0);
      wait_hs("rw_reach2", hs0 + 2, 200);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("rw_busy", busy, 0);
      check("rw_ap_start", ap_start, 0);
      check("rw_run_count", run_count, 0);
      check("rw_kernel_rst", kernel_rst, 0);
      check("rw_done_pulse", done_pulse, 0);
      check("rw_last_cycles", last_run_cycles, 0);

      // Randomized traffic
      k_rand = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clock);
         cfg_start = ($urandom_range(0, 24) == 0);
         cfg_num_runs = RunW'($urandom_range(0, 15));
         cfg_continuous = ($urandom_range(0, 4) == 0);
         cfg_stop = ($urandom_range(0, 59) == 0);
         reset = ($urandom_range(0, 999) == 0);
         if (blk_left > 0) begin
            dl_block = 1'b1;
            blk_left--;
         end else begin
            dl_block = 1'b0;
            if ($urandom_range(0, 29) == 0) blk_left = int'($urandom_range(1, 10));
         end
      end
      @(negedge clock);
      cfg_start = 1'b0; cfg_stop = 1'b0; reset = 1'b0; dl_block = 1'b0;
      repeat (2) @(negedge clock);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
